// File: rtl/lfsr_4bit_if.sv
// Seed-load / state-output bundle for the 4-bit LFSR.
// The master drives sel and seed, and the slave returns the registered state on wint.
interface lfsr_4bit_if;
   logic       sel;
   logic [3:0] seed;
   logic [3:0] wint;

   modport master (
      output sel,
      output seed,
      input  wint
   );

   modport slave (
      input  sel,
      input  seed,
      output wint
   );
endinterface : lfsr_4bit_if

// File: rtl/lfsr_4bit.sv
// 4-bit maximal-length Fibonacci LFSR (x^4 + x^3 + 1) with synchronous seed load.
// The generator steps through all 15 non-zero states and cannot stay stuck at zero.
module lfsr_4bit (
   input  logic        clkslow,
   input  logic        rst,
   lfsr_4bit_if.slave  bus
);

   localparam logic [3:0] ESCAPE_STATE = 4'b0001;

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;
   logic       fb;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      lfsr_d = lfsr_q;
      fb     = lfsr_q[3] ^ lfsr_q[2];

      if (bus.sel) begin
         lfsr_d = (bus.seed == 4'b0000) ? ESCAPE_STATE : bus.seed;
      end else if (lfsr_q == 4'b0000) begin
         // All-zero is a fixed point of the XOR feedback, so kick it onto the sequence.
         lfsr_d = ESCAPE_STATE;
      end else begin
         lfsr_d = {lfsr_q[2:0], fb};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clkslow or posedge rst) begin
      if (rst) begin
         lfsr_q <= 4'b0000;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign bus.wint = lfsr_q;

endmodule : lfsr_4bit

// File: tb/tb_lfsr_4bit.sv
// Directed self-checking bench for lfsr_4bit.
// All expected values are hand-computed from the x^4 + x^3 + 1 sequence.
module tb_lfsr_4bit;

   logic clkslow;
   logic rst;
   int   tests_run;
   int   tests_failed;

   lfsr_4bit_if u_if ();

   lfsr_4bit u_dut (
      .clkslow (clkslow),
      .rst     (rst),
      .bus     (u_if.slave)
   );

   initial clkslow = 1'b0;
   always #5 clkslow = ~clkslow;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clkslow);
      #1;
   endtask

   logic [3:0] exp_seq [15];
   logic       seen    [16];

   initial begin
      exp_seq = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                  4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                  4'b1111};
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      u_if.sel     = 1'b0;
      u_if.seed    = 4'b0000;

      // 1. Asynchronous reset between edges.
      @(posedge clkslow);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", u_if.wint, 4'b0000);
      step();
      check("rst_hold", u_if.wint, 4'b0000);

      // 2. Load 1111, then two shifts.
      rst       = 1'b0;
      u_if.sel  = 1'b1;
      u_if.seed = 4'b1111;
      step();
      check("load_1111", u_if.wint, 4'b1111);
      u_if.sel = 1'b0;
      step();
      check("shift1", u_if.wint, 4'b1110);
      step();
      check("shift2", u_if.wint, 4'b1100);

      // 3. Full period from 1111, with no repeat and no zero.
      u_if.sel = 1'b1;
      step();
      u_if.sel = 1'b0;
      for (int i = 0; i < 16; i++) seen[i] = 1'b0;
      seen[15] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         check($sformatf("seq[%0d]", i), u_if.wint, exp_seq[i]);
         if (i < 14) begin
            check($sformatf("norep[%0d]", i), {3'b000, seen[u_if.wint]}, 4'b0000);
         end
         check($sformatf("nonzero[%0d]", i), {3'b000, (u_if.wint == 4'b0000)}, 4'b0000);
         seen[u_if.wint] = 1'b1;
      end

      // 4. Zero seed and the lock-up escape after reset.
      u_if.sel  = 1'b1;
      u_if.seed = 4'b0000;
      step();
      check("load_zero", u_if.wint, 4'b0001);
      u_if.sel = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_again", u_if.wint, 4'b0000);
      rst = 1'b0;
      step();
      check("escape1", u_if.wint, 4'b0001);
      step();
      check("escape2", u_if.wint, 4'b0010);

      // 5. Reset mid-sequence at 1001, then load 0110 and shift.
      u_if.sel  = 1'b1;
      u_if.seed = 4'b0100;
      step();
      u_if.sel = 1'b0;
      step();
      check("at_1001", u_if.wint, 4'b1001);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst", u_if.wint, 4'b0000);
      rst       = 1'b0;
      u_if.sel  = 1'b1;
      u_if.seed = 4'b0110;
      step();
      check("load_0110", u_if.wint, 4'b0110);
      u_if.sel = 1'b0;
      step();
      check("shift_0110", u_if.wint, 4'b1101);

      // 6. Seed tracking with sel=1, and seed ignored with sel=0.
      u_if.sel  = 1'b1;
      u_if.seed = 4'b1010;
      step();
      check("track_1010", u_if.wint, 4'b1010);
      u_if.seed = 4'b0101;
      step();
      check("track_0101", u_if.wint, 4'b0101);
      step();
      check("static_0101", u_if.wint, 4'b0101);
      u_if.sel  = 1'b0;
      u_if.seed = 4'b0000;
      step();
      check("ign_seed1", u_if.wint, 4'b1011);
      u_if.seed = 4'b1111;
      step();
      check("ign_seed2", u_if.wint, 4'b0111);
      u_if.seed = 4'b1000;
      step();
      check("ign_seed3", u_if.wint, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_lfsr_4bit
